// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and loader state type for the nn image loader
package nn_pkg;

    localparam int IMG_W   = 28;
    localparam int NUM_PIX = IMG_W * IMG_W;
    localparam int PRED_W  = 5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down counter with a zero flag
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/nn_image_loader.sv
// rtl/nn_image_loader.sv - collects a pixel stream into an image vector and samples the nn prediction
module nn_image_loader #(
    parameter int NUM_PIX       = nn_pkg::NUM_PIX,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic                      pix_data,
    input  logic                      pix_last,
    output logic                      data [NUM_PIX-1:0],
    input  logic [nn_pkg::PRED_W-1:0] nn_prediction,
    output logic [nn_pkg::PRED_W-1:0] result,
    output logic                      result_valid,
    input  logic                      result_ack,
    output logic                      frame_err
);
    import nn_pkg::*;

    localparam int CNT_W = 10;
    localparam int TW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    loader_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_PIX-1:0] data_q, data_d;
    logic [PRED_W-1:0]  result_q, result_d;
    logic               rv_q, rv_d;
    logic               ferr_q, ferr_d;
    logic               tmr_load, tmr_en, tmr_done;
    logic               at_end;

    settle_timer #(.W(TW)) u_settle_timer (
        .clk      (Clk),
        .reset    (Reset),
        .load     (tmr_load),
        .load_val (TW'(SETTLE_CYCLES - 1)),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    assign at_end = (cnt_q == CNT_W'(NUM_PIX - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        result_d = result_q;
        rv_d     = rv_q;
        ferr_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (pix_valid) begin
                    data_d[cnt_q] = pix_data;
                    if (at_end && pix_last) begin
                        cnt_d    = '0;
                        tmr_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end else if (at_end || pix_last) begin
                        // Misframed beat: restart the frame but keep bits already written
                        ferr_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    result_d = nn_prediction;
                    rv_d     = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    rv_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            ferr_q   <= ferr_d;
        end
    end

    for (genvar i = 0; i < NUM_PIX; i++) begin : g_data
        assign data[i] = data_q[i];
    end

    assign pix_ready    = (state_q == ST_LOAD) && !Reset;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_nn_image_loader.sv
// tb/tb_nn_image_loader.sv - scoreboard bench for nn_image_loader with a frame-level reference model
module tb_nn_image_loader;

    localparam int NUM_PIX = 784;
    localparam int SETTLE  = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       pix_data = 1'b0;
    logic       pix_last = 1'b0;
    logic       data [NUM_PIX-1:0];
    logic [4:0] nn_prediction = 5'd0;
    logic [4:0] result;
    logic       result_valid;
    logic       result_ack = 1'b0;
    logic       frame_err;

    nn_image_loader #(.NUM_PIX(NUM_PIX), .SETTLE_CYCLES(SETTLE)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_last      (pix_last),
        .data          (data),
        .nn_prediction (nn_prediction),
        .result        (result),
        .result_valid  (result_valid),
        .result_ack    (result_ack),
        .frame_err     (frame_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0] pred;
        int         t0;
    } res_t;

    res_t               res_q [$];
    int                 err_q [$];
    logic [NUM_PIX-1:0] img_q [$];
    logic [NUM_PIX-1:0] exp_img = '0;
    int                 model_idx = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int data_diff(logic [NUM_PIX-1:0] e);
        int n = 0;
        for (int i = 0; i < NUM_PIX; i++) begin
            if (data[i] !== e[i]) n++;
        end
        return n;
    endfunction

    // Reference model: one accepted beat at a time, frame rules applied to a plain index
    function automatic void model_accept(logic d, logic last);
        exp_img[model_idx] = d;
        if (model_idx == NUM_PIX - 1 && last) begin
            res_q.push_back('{pred: nn_prediction, t0: cyc});
            img_q.push_back(exp_img);
            model_idx = 0;
        end else if (model_idx == NUM_PIX - 1 || last) begin
            err_q.push_back(cyc);
            model_idx = 0;
        end else begin
            model_idx++;
        end
    endfunction

    res_t               mon_r;
    logic [NUM_PIX-1:0] mon_img;
    int                 mon_t;
    logic               rv_prev = 1'b0;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (result_valid && !rv_prev) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    mon_r   = res_q.pop_front();
                    mon_img = img_q.pop_front();
                    chk("result", int'(result), int'(mon_r.pred));
                    chk("latency", cyc - mon_r.t0 + 1, SETTLE + 1);
                    chk("image_bits_wrong", data_diff(mon_img), 0);
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_frame_err", 1, 0);
                end else begin
                    mon_t = err_q.pop_front();
                    chk("frame_err_cycle", cyc, mon_t);
                end
            end
        end
        rv_prev = result_valid;
    end

    task automatic beat(logic d, logic last, bit gaps);
        int  guard = 0;
        bit  acc = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                pix_valid = 1'b0;
                pix_data  = 1'($urandom);
                pix_last  = 1'($urandom);
                @(posedge Clk); #1;
            end
        end
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        while (!acc && guard < 1000) begin
            @(negedge Clk);
            acc = pix_ready;
            @(posedge Clk); #1;
            guard++;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        if (!acc) chk("beat_accept_timeout", 0, 1);
        else      model_accept(d, last);
    endtask

    // pat 0: pixel k = k%2, pat 1: random pixels
    task automatic frame(logic [4:0] pred, bit gaps, int pat);
        nn_prediction = pred;
        for (int k = 0; k < NUM_PIX; k++) begin
            beat((pat == 0) ? 1'(k % 2) : 1'($urandom), k == NUM_PIX - 1, gaps);
        end
    endtask

    task automatic wait_valid();
        int g = 0;
        result_ack = 1'b1;
        repeat (8) begin @(posedge Clk); #1; end
        result_ack = 1'b0;
        while (!result_valid && g < 100) begin
            @(negedge Clk);
            g++;
        end
        if (!result_valid) chk("result_valid_timeout", 0, 1);
        @(posedge Clk); #1;
    endtask

    task automatic finish_frame();
        wait_valid();
        repeat ($urandom_range(5, 0)) begin @(posedge Clk); #1; end
        result_ack = 1'b1;
        @(posedge Clk); #1;
        result_ack = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge Clk);
        chk("rst_pix_ready", pix_ready, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_pix_ready_after", pix_ready, 1);
        chk("rst_result", int'(result), 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_data_nonzero", data_diff('0), 0);
        @(posedge Clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    logic [4:0] held;
    int         bad;

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs();

        // Alternating-pixel frame, prediction 7, then a long stall in DONE
        frame(5'd7, 0, 0);
        wait_valid();
        held      = result;
        bad       = 0;
        pix_valid = 1'b1;
        pix_data  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (pix_ready !== 1'b0 || result !== held || result_valid !== 1'b1) bad++;
            @(posedge Clk); #1;
        end
        chk("done_hold_violations", bad, 0);
        result_ack = 1'b1;
        @(posedge Clk); #1;
        result_ack = 1'b0;
        pix_valid  = 1'b0;
        @(negedge Clk);
        chk("ack_result_valid", result_valid, 0);
        chk("ack_pix_ready", pix_ready, 1);
        chk("ack_result_retained", int'(result), int'(held));
        @(posedge Clk); #1;

        // Early pix_last at beat 100, then a full frame with an out-of-range prediction
        for (int k = 0; k <= 100; k++) beat(1'($urandom), k == 100, 0);
        frame(5'd25, 0, 1);
        finish_frame();

        // Missing pix_last on the final index
        for (int k = 0; k < NUM_PIX; k++) beat(1'($urandom), 1'b0, 0);
        @(negedge Clk);
        chk("nolast_pix_ready", pix_ready, 1);
        repeat (25) @(negedge Clk);
        chk("nolast_no_result", result_valid, 0);
        @(posedge Clk); #1;

        frame(5'($urandom), 0, 1);
        finish_frame();

        // Reset in the middle of a frame
        for (int k = 0; k < 400; k++) beat(1'($urandom), 1'b0, 0);
        Reset     = 1'b1;
        exp_img   = '0;
        model_idx = 0;
        check_reset_outputs();

        // Gapped alternating frame must rebuild the same image from index 0
        frame(5'($urandom), 1, 0);
        finish_frame();

        repeat (5) begin @(posedge Clk); #1; end
        chk("results_outstanding", res_q.size(), 0);
        chk("errors_outstanding", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
